// File: rtl/fp_divider_if.sv
// ---------------------------------------------------------------------------
// fp_divider_if
// Start/done handshake and operand/result bundle for fp_divider.
//   start          : request, honoured only while busy is low
//   A, B           : dividend / divisor, captured on the accepted start edge
//   busy           : division in progress
//   done           : one-cycle pulse, out and flags valid from this cycle
//   out            : quotient, held until rewritten
//   overflow_flag  : exponent overflow, out = +/-inf
//   underflow_flag : exponent underflow, out = +/-0
//   divzero_flag   : finite nonzero / zero
//   invalid_flag   : 0/0, inf/inf or NaN operand
// master drives requests, slave is the divider.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface fp_divider_if #(
   parameter int X = 32
);
   logic         start;
   logic [X-1:0] A;
   logic [X-1:0] B;
   logic         busy;
   logic         done;
   logic [X-1:0] out;
   logic         overflow_flag;
   logic         underflow_flag;
   logic         divzero_flag;
   logic         invalid_flag;

   modport master (
      output start, A, B,
      input  busy, done, out, overflow_flag, underflow_flag, divzero_flag, invalid_flag
   );

   modport slave (
      input  start, A, B,
      output busy, done, out, overflow_flag, underflow_flag, divzero_flag, invalid_flag
   );
endinterface

// File: rtl/fp_divider.sv
// ---------------------------------------------------------------------------
// fp_divider
// Sequential IEEE-754 divider, out = A / B, for X = 32 or 64.
// Mantissas are divided by restoring division, one quotient bit per clock,
// followed by a single normalisation cycle. Results are truncated.
// Special cases (NaN, inf, zero/subnormal operands) finish on the start edge.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fp_divider_if slave (start, A, B, busy, done, out, flags)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fp_divider #(
   parameter int X = 32
) (
   input logic         clk,
   input logic         rst_n,
   fp_divider_if.slave bus
);
   localparam int EB = (X == 64) ? 11 : 8;
   localparam int MB = X - 1 - EB;
   localparam int Q  = MB + 2;
   localparam int EW = EB + 2;
   localparam int CW = $clog2(Q + 1);
   localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EB - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX  = EW'((1 << EB) - 1);
   localparam logic signed [EW-1:0] EONE  = EW'(1);
   localparam logic signed [EW-1:0] EZERO = '0;

   typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic [X-1:0]           out_q, out_d;
   logic                   ovf_q, ovf_d, unf_q, unf_d, dz_q, dz_d, inv_q, inv_d;
   logic [Q-1:0]           rem_q, rem_d, div_q, div_d, quo_q, quo_d;
   logic signed [EW-1:0]   exp_q, exp_d;
   logic                   sign_q, sign_d;
   logic [Q-1:0]           rem_sel;
   logic signed [EW-1:0]   norm_e;
   logic [MB-1:0]          norm_m;

   // Range check after normalisation: returns {overflow, underflow, result}.
   function automatic logic [X+1:0] pack_result(input logic s,
                                                input logic signed [EW-1:0] e,
                                                input logic [MB-1:0] m);
      if (e >= EMAX)
         pack_result = {2'b10, s, {EB{1'b1}}, {MB{1'b0}}};
      else if (e <= EZERO)
         pack_result = {2'b01, s, {(X-1){1'b0}}};
      else
         pack_result = {2'b00, s, e[EB-1:0], m};
   endfunction

   // Operand classification; exp == 0 (zero or subnormal) counts as zero.
   logic [EB-1:0] a_exp, b_exp;
   logic [MB-1:0] a_man, b_man;
   logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s_in;

   assign a_exp  = bus.A[X-2:MB];
   assign b_exp  = bus.B[X-2:MB];
   assign a_man  = bus.A[MB-1:0];
   assign b_man  = bus.B[MB-1:0];
   assign a_nan  = (&a_exp) && (|a_man);
   assign b_nan  = (&b_exp) && (|b_man);
   assign a_inf  = (&a_exp) && !(|a_man);
   assign b_inf  = (&b_exp) && !(|b_man);
   assign a_zero = !(|a_exp);
   assign b_zero = !(|b_exp);
   assign s_in   = bus.A[X-1] ^ bus.B[X-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      out_d   = out_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      dz_d    = dz_q;
      inv_d   = inv_q;
      rem_d   = rem_q;
      div_d   = div_q;
      quo_d   = quo_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      rem_sel = rem_q;
      norm_e  = exp_q;
      norm_m  = quo_q[Q-2:1];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               ovf_d  = 1'b0;
               unf_d  = 1'b0;
               dz_d   = 1'b0;
               inv_d  = 1'b0;
               sign_d = s_in;
               if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                  out_d  = {s_in, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
                  inv_d  = 1'b1;
                  done_d = 1'b1;
               end else if (a_inf) begin
                  out_d  = {s_in, {EB{1'b1}}, {MB{1'b0}}};
                  done_d = 1'b1;
               end else if (b_zero) begin
                  out_d  = {s_in, {EB{1'b1}}, {MB{1'b0}}};
                  dz_d   = 1'b1;
                  done_d = 1'b1;
               end else if (a_zero || b_inf) begin
                  out_d  = {s_in, {(X-1){1'b0}}};
                  done_d = 1'b1;
               end else begin
                  rem_d   = {2'b01, a_man};
                  div_d   = {2'b01, b_man};
                  quo_d   = '0;
                  exp_d   = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;
                  cnt_d   = '0;
                  state_d = DIVIDE;
               end
            end
         end
         DIVIDE: begin
            // Remainder stays below twice the divisor, so the shift never loses a set bit.
            if (rem_q >= div_q) begin
               rem_sel = rem_q - div_q;
               quo_d   = {quo_q[Q-2:0], 1'b1};
            end else begin
               quo_d   = {quo_q[Q-2:0], 1'b0};
            end
            rem_d = rem_sel << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(Q - 1))
               state_d = NORM;
         end
         NORM: begin
            // Quotient lies in (0.5, 2): either the integer bit or the next bit leads.
            if (!quo_q[Q-1]) begin
               norm_m = quo_q[Q-3:0];
               norm_e = exp_q - EONE;
            end
            {ovf_d, unf_d, out_d} = pack_result(sign_q, norm_e, norm_m);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and architected outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         dz_q    <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         dz_q    <= dz_d;
         inv_q   <= inv_d;
      end
   end

   // Division datapath
   always_ff @(posedge clk) begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quo_q  <= quo_d;
      exp_q  <= exp_d;
      sign_q <= sign_d;
   end

   assign bus.busy           = (state_q != IDLE);
   assign bus.done           = done_q;
   assign bus.out            = out_q;
   assign bus.overflow_flag  = ovf_q;
   assign bus.underflow_flag = unf_q;
   assign bus.divzero_flag   = dz_q;
   assign bus.invalid_flag   = inv_q;
endmodule

// File: tb/tb_fp_divider.sv
`timescale 1ns/1ps
module tb_fp_divider;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   fp_divider_if #(.X(32)) bus ();
   fp_divider #(.X(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // flags packed as {overflow, underflow, divzero, invalid}
   typedef struct packed {
      logic        special;
      logic [3:0]  flags;
      logic [31:0] val;
   } res_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] o;
      logic [3:0]  f;
      logic [7:0]  lat;
   } vec_t;

   logic [3:0] flags_vec;
   assign flags_vec = {bus.overflow_flag, bus.underflow_flag, bus.divzero_flag, bus.invalid_flag};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact integer quotient of the 24-bit significands scaled by 2^24,
   // then the normalise / truncate / range rules on plain integers.
   function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b);
      res_t        r;
      logic        s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      int          ea, eb, e;
      logic [63:0] num, den, q;
      logic [22:0] m;
      s      = a[31] ^ b[31];
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      nan_a  = (ea == 255) && (a[22:0] != 0);
      nan_b  = (eb == 255) && (b[22:0] != 0);
      inf_a  = (ea == 255) && (a[22:0] == 0);
      inf_b  = (eb == 255) && (b[22:0] == 0);
      zero_a = (ea == 0);
      zero_b = (eb == 0);
      r.special = 1'b1;
      r.flags   = 4'b0000;
      r.val     = 32'h0;
      if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
         r.val = {s, 8'hFF, 1'b1, 22'd0}; r.flags = 4'b0001;
      end else if (inf_a) begin
         r.val = {s, 8'hFF, 23'd0};
      end else if (zero_b) begin
         r.val = {s, 8'hFF, 23'd0}; r.flags = 4'b0010;
      end else if (zero_a || inf_b) begin
         r.val = {s, 31'd0};
      end else begin
         r.special = 1'b0;
         num = ((64'd1 << 23) + 64'(a[22:0])) << 24;
         den = (64'd1 << 23) + 64'(b[22:0]);
         q   = num / den;
         e   = ea - eb + 127;
         if (q[24]) m = q[23:1];
         else begin m = q[22:0]; e = e - 1; end
         if (e >= 255) begin r.val = {s, 8'hFF, 23'd0}; r.flags = 4'b1000; end
         else if (e <= 0) begin r.val = {s, 31'd0}; r.flags = 4'b0100; end
         else r.val = {s, e[7:0], m};
      end
      return r;
   endfunction

   function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
             (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
   endfunction

   // Timing model: edge counter plus the expected done edge of the accepted request.
   int   ecnt = 0;
   int   m_done_edge = -1;
   logic m_busy = 1'b0;
   logic m_have = 1'b0;
   res_t m_res = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ecnt        <= 0;
         m_busy      <= 1'b0;
         m_done_edge <= -1;
         m_have      <= 1'b1;
         m_res       <= '0;
      end else begin
         ecnt <= ecnt + 1;
         if (bus.start && !m_busy) begin
            m_res  <= ref_div(bus.A, bus.B);
            m_have <= 1'b1;
            if (is_special(bus.A, bus.B)) begin
               m_done_edge <= ecnt + 1;
               m_busy      <= 1'b0;
            end else begin
               m_done_edge <= ecnt + 1 + 26;
               m_busy      <= 1'b1;
            end
         end else if (m_busy && (ecnt + 1 == m_done_edge)) begin
            m_busy <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("done", 64'(bus.done), 64'(m_done_edge == ecnt));
      if (m_busy)
         check("flags_cleared", 64'(flags_vec), 64'd0);
      else if (m_have) begin
         check("out", 64'(bus.out), 64'(m_res.val));
         check("flags", 64'(flags_vec), 64'(m_res.flags));
      end
   end

   task automatic pulse_now(input logic [31:0] a, input logic [31:0] b, output int e);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      e = ecnt;
   endtask

   task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, output int e);
      @(negedge clk);
      pulse_now(a, b, e);
   endtask

   task automatic wait_done(input int e0, output int lat, output bit ok);
      ok  = 1'b0;
      lat = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ok  = 1'b1;
            lat = ecnt - e0;
            break;
         end
      end
      if (!ok) check("done_timeout", 64'd0, 64'd1);
   endtask

   vec_t vecs [12] = '{
      '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 8'd26},
      '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 8'd26},
      '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 8'd26},
      '{32'hC0000000, 32'h3F000000, 32'hC0800000, 4'b0000, 8'd26},
      '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 8'd0},
      '{32'hBF800000, 32'h80000000, 32'h7F800000, 4'b0010, 8'd0},
      '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 8'd0},
      '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0001, 8'd0},
      '{32'hFFC00000, 32'h3F800000, 32'hFFC00000, 4'b0001, 8'd0},
      '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 8'd0},
      '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, 8'd26},
      '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 8'd26}
   };

   initial begin
      res_t r;
      int   e0, lat;
      bit   ok, seen;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;

      // Hand-computed pins on the reference model
      r = ref_div(32'h40C00000, 32'h40000000);
      check("model_6div2", 64'(r.val), 64'h40400000);
      r = ref_div(32'h3F800000, 32'h40400000);
      check("model_1div3", 64'(r.val), 64'h3EAAAAAA);
      r = ref_div(32'h7F000000, 32'h3E800000);
      check("model_ovf", 64'({r.flags, r.val}), 64'h87F800000);
      r = ref_div(32'h00800000, 32'h40000000);
      check("model_unf", 64'({r.flags, r.val}), 64'h400000000);

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_out", 64'(bus.out), 64'd0);
      check("rst_flags", 64'(flags_vec), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      foreach (vecs[i]) begin
         pulse_start(vecs[i].a, vecs[i].b, e0);
         wait_done(e0, lat, ok);
         if (ok) begin
            check($sformatf("vec%0d_out", i), 64'(bus.out), 64'(vecs[i].o));
            check($sformatf("vec%0d_flags", i), 64'(flags_vec), 64'(vecs[i].f));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         end
         repeat (2) @(posedge clk);
      end

      // Start while busy is ignored
      pulse_start(32'h40C00000, 32'h40000000, e0);
      repeat (9) @(posedge clk);
      pulse_start(32'h3F800000, 32'h40400000, lat);
      wait_done(e0, lat, ok);
      if (ok) begin
         check("busy_start_out", 64'(bus.out), 64'h40400000);
         check("busy_start_latency", 64'(lat), 64'd26);
      end

      // Start in the done cycle is accepted
      repeat (2) @(posedge clk);
      pulse_start(32'h40C00000, 32'h40000000, e0);
      wait_done(e0, lat, ok);
      pulse_now(32'h3F800000, 32'h40400000, e0);
      wait_done(e0, lat, ok);
      if (ok) begin
         check("b2b_out", 64'(bus.out), 64'h3EAAAAAA);
         check("b2b_latency", 64'(lat), 64'd26);
      end

      // Reset mid-division
      repeat (2) @(posedge clk);
      pulse_start(32'hC0C00000, 32'h40000000, e0);
      repeat (11) @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_out", 64'(bus.out), 64'd0);
      check("abort_flags", 64'(flags_vec), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      pulse_start(32'hC0C00000, 32'h40000000, e0);
      wait_done(e0, lat, ok);
      if (ok) begin
         check("after_reset_out", 64'(bus.out), 64'hC0400000);
         check("after_reset_latency", 64'(lat), 64'd26);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
